// File: rtl/scan_reg_n.sv
// scan_reg_n: WIDTH-bit scan register bank with shadow update stage and shift-load counter
//
// Ports:
//   C              clock, all state changes on the rising edge
//   global_reset_n asynchronous active-low reset (clears Q, UQ, shift_cnt)
//   MISR_MODE      signature compaction on CE (only when SCAN_MISR_EN is defined)
//   D              functional parallel data
//   CE             functional load enable
//   NbarT          test mode, 1 = serial shift
//   Si / So        serial scan in (enters MSB) / serial scan out (Q[0])
//   CLR / PRE      synchronous clear / preset of the capture stage
//   UPD            copy the pre-edge capture stage into the update stage
//   Q / UQ         capture stage / update (shadow) stage
//   shift_cnt      consecutive shift cycles, saturating at WIDTH
//   shift_done     high while shift_cnt == WIDTH
//
// Optional feature: define SCAN_MISR_EN to add MISR_MODE and POLY-based
// signature compaction on the CE path.
//
// TPHL/TPLH are the transition delays of Q, UQ and So for back-annotated
// gate-level timing; this RTL model is zero-delay.
module scan_reg_n #(
    parameter int              WIDTH = 8,
    parameter int              TPHL  = 0,
    parameter int              TPLH  = 0,
    parameter logic [WIDTH-1:0] POLY = WIDTH'(8'h1D)
) (
    input  logic                       C,
    input  logic                       global_reset_n,
`ifdef SCAN_MISR_EN
    input  logic                       MISR_MODE,
`endif
    input  logic [WIDTH-1:0]           D,
    input  logic                       CE,
    input  logic                       NbarT,
    input  logic                       Si,
    output logic                       So,
    input  logic                       CLR,
    input  logic                       PRE,
    input  logic                       UPD,
    output logic [WIDTH-1:0]           Q,
    output logic [WIDTH-1:0]           UQ,
    output logic [$clog2(WIDTH+1)-1:0] shift_cnt,
    output logic                       shift_done
);
    localparam int CW = $clog2(WIDTH+1);
    logic [WIDTH-1:0] q_q, q_d, uq_q, uq_d, load_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             unused_params;
    assign unused_params = (TPHL != 0) ^ (TPLH != 0) ^ (^POLY);
`ifdef SCAN_MISR_EN
    // Galois-style MISR: shift left, fold the outgoing MSB through POLY, mix in D.
    always_comb load_d = MISR_MODE ? (({q_q[WIDTH-2:0], 1'b0} ^ (q_q[WIDTH-1] ? POLY : '0)) ^ D) : D;
`else
    always_comb load_d = D;
`endif
    always_comb q_d = CLR ? '0 : PRE ? '1 : NbarT ? {Si, q_q[WIDTH-1:1]} : CE ? load_d : q_q;
    always_comb uq_d = UPD ? q_q : uq_q;
    // Only an uninterrupted run of pure shift edges advances the count.
    always_comb cnt_d = (CLR || PRE || !NbarT) ? '0 : (cnt_q == CW'(WIDTH)) ? cnt_q : cnt_q + CW'(1);
    always_ff @(posedge C or negedge global_reset_n) begin
        if (!global_reset_n) begin
            q_q   <= '0;
            uq_q  <= '0;
            cnt_q <= '0;
        end else begin
            q_q   <= q_d;
            uq_q  <= uq_d;
            cnt_q <= cnt_d;
        end
    end
    assign Q          = q_q;
    assign UQ         = uq_q;
    assign So         = q_q[0];
    assign shift_cnt  = cnt_q;
    assign shift_done = (cnt_q == CW'(WIDTH));
endmodule

// File: tb/tb_scan_reg_n.sv
// tb_scan_reg_n: randomized self-checking bench for scan_reg_n against a behavioural model
module tb_scan_reg_n;
    localparam int W = 8;
    localparam int POLY = 'h1D;
    localparam int MASK = (1 << W) - 1;
    logic       C = 0, rst_n = 0;
    logic [W-1:0] D = 0;
    logic       CE = 0, NbarT = 0, Si = 0, CLR = 0, PRE = 0, UPD = 0, MISR_MODE = 0;
    logic       So, shift_done;
    logic [W-1:0] Q, UQ;
    logic [$clog2(W+1)-1:0] shift_cnt;
    int vectors = 0, miscompares = 0;
    int m_q = 0, m_uq = 0, m_cnt = 0;
    bit chk_en = 0;

    scan_reg_n #(.WIDTH(W)) dut (
        .C(C), .global_reset_n(rst_n),
`ifdef SCAN_MISR_EN
        .MISR_MODE(MISR_MODE),
`endif
        .D(D), .CE(CE), .NbarT(NbarT), .Si(Si), .So(So), .CLR(CLR), .PRE(PRE),
        .UPD(UPD), .Q(Q), .UQ(UQ), .shift_cnt(shift_cnt), .shift_done(shift_done)
    );

    always #5 C = ~C;

    // Reference: next Q from the control priority, written as plain integer arithmetic.
    always @(posedge C or negedge rst_n) begin
        int nq;
        if (!rst_n) begin
            m_q = 0; m_uq = 0; m_cnt = 0;
        end else begin
            if (CLR) nq = 0;
            else if (PRE) nq = MASK;
            else if (NbarT) nq = (int'(Si) << (W - 1)) | (m_q >> 1);
            else if (CE) begin
`ifdef SCAN_MISR_EN
                if (MISR_MODE) nq = ((m_q * 2) & MASK) ^ (((m_q >> (W - 1)) & 1) != 0 ? POLY : 0) ^ int'(D);
                else nq = int'(D);
`else
                nq = int'(D);
`endif
            end else nq = m_q;
            if (UPD) m_uq = m_q;
            m_q = nq;
            m_cnt = (NbarT && !CLR && !PRE) ? ((m_cnt + 1 > W) ? W : m_cnt + 1) : 0;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge C) if (chk_en) begin
        check("model_q", 64'(Q), 64'(m_q));
        check("model_uq", 64'(UQ), 64'(m_uq));
        check("model_so", 64'(So), 64'(m_q & 1));
        check("model_cnt", 64'(shift_cnt), 64'(m_cnt));
        check("model_done", 64'(shift_done), 64'(m_cnt == W));
    end

    task automatic cyc(input logic clr, input logic pre, input logic nt, input logic si,
                       input logic ce, input logic [W-1:0] d, input logic upd, input logic mm);
        CLR = clr; PRE = pre; NbarT = nt; Si = si; CE = ce; D = d; UPD = upd; MISR_MODE = mm;
        @(posedge C);
        #2;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, '0, 0, 0);
    endtask

    initial begin
        logic [7:0] bits;
        bits = 8'b0100_1101;
        rst_n = 0;
        repeat (2) @(posedge C);
        #2 rst_n = 1;
        chk_en = 1;
        repeat (3) idle();
        check("rst_q", 64'(Q), 64'h00);
        check("rst_uq", 64'(UQ), 64'h00);
        check("rst_so", 64'(So), 64'h0);
        check("rst_cnt", 64'(shift_cnt), 64'h0);
        check("rst_done", 64'(shift_done), 64'h0);
        for (int i = 0; i < 8; i++) cyc(0, 0, 1, bits[i], 0, '0, 0, 0);
        check("load_q", 64'(Q), 64'h4D);
        check("load_cnt", 64'(shift_cnt), 64'd8);
        check("load_done", 64'(shift_done), 64'h1);
        cyc(0, 0, 1, 1, 0, '0, 0, 0);
        check("sat_q", 64'(Q), 64'hA6);
        check("sat_done", 64'(shift_done), 64'h1);
        check("sat_so", 64'(So), 64'h0);
        cyc(0, 0, 0, 0, 1, 8'h4D, 0, 0);
        check("cnt_clr", 64'(shift_cnt), 64'h0);
        cyc(0, 0, 0, 0, 1, 8'hF0, 1, 0);
        check("coll_uq", 64'(UQ), 64'h4D);
        check("coll_q", 64'(Q), 64'hF0);
        cyc(0, 0, 0, 0, 0, '0, 1, 0);
        check("upd_uq", 64'(UQ), 64'hF0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1, 0, '0, 0, 0);
        cyc(1, 1, 1, 1, 1, 8'h55, 0, 0);
        check("prio_q", 64'(Q), 64'h00);
        check("prio_cnt", 64'(shift_cnt), 64'h0);
        cyc(0, 1, 0, 0, 0, '0, 0, 0);
        check("pre_q", 64'(Q), 64'hFF);
        check("pre_uq", 64'(UQ), 64'hF0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, 0, '0, 0, 0);
        check("mid_cnt", 64'(shift_cnt), 64'd5);
        rst_n = 0;
        #1;
        check("arst_q", 64'(Q), 64'h00);
        check("arst_uq", 64'(UQ), 64'h00);
        check("arst_cnt", 64'(shift_cnt), 64'h0);
        #1 rst_n = 1;
        idle();
`ifdef SCAN_MISR_EN
        cyc(0, 0, 0, 0, 1, 8'h80, 0, 0);
        cyc(0, 0, 0, 0, 1, 8'h00, 0, 1);
        check("misr1_q", 64'(Q), 64'h1D);
        cyc(0, 0, 0, 0, 1, 8'h01, 0, 1);
        check("misr2_q", 64'(Q), 64'h3B);
`endif
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0,
                1'($urandom), 1'($urandom), W'($urandom), $urandom_range(0, 3) == 0, 1'($urandom));
            if ($urandom_range(0, 99) == 0) begin
                #1 rst_n = 0;
                #1 rst_n = 1;
            end
        end
        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
